toy_bpu_l0btb_alloc: RTL and testbench
======================================

TOY_BPU_L0BTB_ALLOC -- requirements
Module: toy_bpu_l0btb_alloc

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 8, number of L0 BTB entries (power of 2, 2..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, depth of the update request queue.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the clock is clk and the reset is rst_n.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  async active-low reset.
REQ-006 upd_vld  input  1  update request valid.
REQ-007 upd_rdy  output  1  request queue can accept a request.
REQ-008 upd_inv  input  1  request is an invalidate, not a write.
REQ-009 upd_pld  input  $bits(l0btb_entry_pkg)  entry payload; its tag field is the match key.
REQ-010 entry_vld  input  ENTRY_NUM  per-entry valid from the entry instances.
REQ-011 entry_pld  input  ENTRY_NUM x l0btb_entry_pkg  per-entry payload from the entry instances.
REQ-012 entry_update  output  ENTRY_NUM  one-hot per-entry update strobe.
REQ-013 entry_update_inv  output  ENTRY_NUM  per-entry invalidate qualifier.
REQ-014 entry_update_pld  output  l0btb_entry_pkg  payload broadcast to all entries.
REQ-015 victim_ptr  output  $clog2(ENTRY_NUM)  round-robin replacement pointer (debug).

Function
REQ-016 Request accepted on the cycle where upd_vld && upd_rdy; upd_rdy SHALL be 1 whenever the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-017 One FIFO entry SHALL be popped per cycle when the FIFO is non-empty; the FIFO is first-in, first-out with no reordering.
REQ-018 Lookup on pop: hit = entry_vld[i] && entry_pld[i].tag == head.tag; a hit SHALL select the lowest matching index.
REQ-019 Hit && !inv: strobe the hit entry, inv=0, pld=head pld (overwrite in place, no new allocation).
REQ-020 Hit && inv: strobe the hit entry with entry_update_inv set for that index.
REQ-021 Miss && !inv: strobe the lowest-index invalid entry if one exists; otherwise strobe entry victim_ptr and increment victim_ptr, wrapping from ENTRY_NUM-1 to 0.
REQ-022 Miss && inv: no strobe, request dropped, victim_ptr unchanged.
REQ-023 victim_ptr SHALL change only when a victim replacement is made (REQ-021, all entries valid).
REQ-024 Outputs entry_update/entry_update_inv/entry_update_pld SHALL be registered: the strobe is high exactly one cycle, with latency 1 cycle from pop and 2 cycles from acceptance into an empty FIFO.
REQ-025 Forwarding: lookup SHALL treat the strobe currently on the outputs as already applied to entry_vld/entry_pld, so that back-to-back requests with the same tag hit the same entry and never allocate a duplicate.
REQ-026 entry_update SHALL be zero or one-hot in every cycle; when entry_update is 0, entry_update_inv SHALL be 0.
REQ-027 Acceptance and pop in the same cycle on a full FIFO SHALL keep the count unchanged without loss.

Reset
REQ-028 On rst_n low, the FIFO SHALL empty, victim_ptr=0, entry_update=0, entry_update_inv=0, entry_update_pld=0, and upd_rdy=1 after release.
REQ-029 A reset asserted mid-operation SHALL discard all queued and in-flight requests, and no strobe SHALL be produced in the cycle after release.

Configuration
REQ-030 Macro TOY_BPU_L0BTB_FLUSH_EN SHALL add an input flush (1 bit).
REQ-031 With the macro defined, flush SHALL in the next cycle assert entry_update and entry_update_inv on all ENTRY_NUM bits, empty the FIFO, and set victim_ptr=0; flush has priority over any pop in that cycle, and upd_rdy is 0 while flush is high.
REQ-032 Without the macro, there SHALL be no flush port and the entry_update one-hot rule (REQ-026) holds unconditionally.

Structure
REQ-033 l0btb_entry_pkg (including its tag field), the L0 BTB tag width, and the ENTRY_NUM default SHALL live in toy_pack.
REQ-034 The request FIFO SHALL be one sub-module, toy_bpu_l0btb_updt_fifo; lookup, victim select and the output register stay in this module.

Verification
REQ-035 The bench SHALL cover: after reset, 8 writes with tags 0x10..0x17 -> strobes on entries 0..7 in order, victim_ptr stays 0.
REQ-036 The bench SHALL cover: with all 8 entries valid, writes of tags 0x20, 0x21 -> strobes on entries 0 and 1, victim_ptr goes 0->1->2.
REQ-037 The bench SHALL cover: a write of tag 0x30 immediately followed by a second write of 0x30 -> both strobes hit the same index, with no duplicate entry.
REQ-038 The bench SHALL cover: an invalidate of a hitting tag 0x15 -> entry 5 strobed with inv=1; an invalidate of a missing tag 0x99 -> no strobe.
REQ-039 The bench SHALL cover: upd_vld held high for 6 cycles into an empty FIFO with FIFO_DEPTH=2 -> 6 strobes in 6 consecutive cycles starting 2 cycles later, with no drops.
REQ-040 The bench SHALL cover, with TOY_BPU_L0BTB_FLUSH_EN: a flush while the FIFO holds 2 requests -> all-ones entry_update and entry_update_inv for one cycle, FIFO empty, victim_ptr=0.

Source files
------------

// File: rtl/toy_pack.sv
// Shared L0 BTB types: entry payload, queued update request, default sizing.
package toy_pack;

    localparam int L0BTB_TAG_W     = 8;
    localparam int L0BTB_TGT_W     = 16;
    localparam int L0BTB_ENTRY_NUM = 8;

    typedef struct packed {
        logic [L0BTB_TAG_W-1:0] tag;
        logic [L0BTB_TGT_W-1:0] tgt;
    } l0btb_entry_pkg;

    typedef struct packed {
        logic           inv;
        l0btb_entry_pkg pld;
    } l0btb_upd_req_t;

endpackage

// File: rtl/toy_bpu_l0btb_alloc_if.sv
// Update request handshake into the L0 BTB allocator.
interface toy_bpu_l0btb_alloc_if;

    logic                    upd_vld;
    logic                    upd_rdy;
    logic                    upd_inv;
    toy_pack::l0btb_entry_pkg upd_pld;

    modport master (output upd_vld, output upd_inv, output upd_pld, input  upd_rdy);
    modport slave  (input  upd_vld, input  upd_inv, input  upd_pld, output upd_rdy);

endinterface

// File: rtl/toy_bpu_l0btb_updt_fifo.sv
// Update request queue; clr empties it in one cycle.
module toy_bpu_l0btb_updt_fifo import toy_pack::*; #(
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           push,
    input  l0btb_upd_req_t din,
    input  logic           pop,
    output l0btb_upd_req_t dout,
    output logic           empty,
    output logic           full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    l0btb_upd_req_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // a full queue still accepts when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/toy_bpu_l0btb_alloc.sv
// L0 BTB update allocator: queued requests, tag lookup, free/round-robin victim pick.
// Optional flush port with macro TOY_BPU_L0BTB_FLUSH_EN.
module toy_bpu_l0btb_alloc import toy_pack::*; #(
    parameter  int ENTRY_NUM  = L0BTB_ENTRY_NUM,
    parameter  int FIFO_DEPTH = 2,
    localparam int IDX_W      = $clog2(ENTRY_NUM)
) (
    input  logic                           clk,
    input  logic                           rst_n,
`ifdef TOY_BPU_L0BTB_FLUSH_EN
    input  logic                           flush,
`endif
    toy_bpu_l0btb_alloc_if.slave           upd,
    input  logic           [ENTRY_NUM-1:0] entry_vld,
    input  l0btb_entry_pkg [ENTRY_NUM-1:0] entry_pld,
    output logic           [ENTRY_NUM-1:0] entry_update,
    output logic           [ENTRY_NUM-1:0] entry_update_inv,
    output l0btb_entry_pkg                 entry_update_pld,
    output logic           [IDX_W-1:0]     victim_ptr
);

    logic                           flush_w;
    logic                           push, pop, fifo_empty, fifo_full;
    l0btb_upd_req_t                 head;
    logic           [ENTRY_NUM-1:0] eff_vld;
    l0btb_entry_pkg [ENTRY_NUM-1:0] eff_pld;
    logic                           hit, free;
    logic           [IDX_W-1:0]     hit_idx, free_idx;

    logic [ENTRY_NUM-1:0] entry_update_q, entry_update_d;
    logic [ENTRY_NUM-1:0] entry_update_inv_q, entry_update_inv_d;
    l0btb_entry_pkg       entry_update_pld_q, entry_update_pld_d;
    logic [IDX_W-1:0]     victim_ptr_q, victim_ptr_d;

`ifdef TOY_BPU_L0BTB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign pop         = !fifo_empty && !flush_w;
    assign upd.upd_rdy = !flush_w && (!fifo_full || pop);
    assign push        = upd.upd_vld && upd.upd_rdy;

    toy_bpu_l0btb_updt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush_w),
        .push  (push),
        .din   ({upd.upd_inv, upd.upd_pld}),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // The strobe on the outputs lands in the entries next edge; look up as if it already has.
    for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_fwd
        assign eff_vld[g] = entry_update_q[g] ? !entry_update_inv_q[g] : entry_vld[g];
        assign eff_pld[g] = entry_update_q[g] ? entry_update_pld_q     : entry_pld[g];
    end

    // Descending scan so the lowest matching / lowest free index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (eff_vld[i] && (eff_pld[i].tag == head.pld.tag)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!eff_vld[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        entry_update_d     = '0;
        entry_update_inv_d = '0;
        entry_update_pld_d = entry_update_pld_q;
        victim_ptr_d       = victim_ptr_q;
        if (flush_w) begin
            entry_update_d     = '1;
            entry_update_inv_d = '1;
            victim_ptr_d       = '0;
        end else if (pop) begin
            if (hit) begin
                entry_update_d[hit_idx]     = 1'b1;
                entry_update_inv_d[hit_idx] = head.inv;
                entry_update_pld_d          = head.pld;
            end else if (!head.inv) begin
                entry_update_pld_d = head.pld;
                if (free) begin
                    entry_update_d[free_idx] = 1'b1;
                end else begin
                    entry_update_d[victim_ptr_q] = 1'b1;
                    victim_ptr_d = (victim_ptr_q == IDX_W'(ENTRY_NUM - 1)) ? '0
                                                                           : victim_ptr_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_update_q     <= '0;
            entry_update_inv_q <= '0;
            entry_update_pld_q <= '0;
            victim_ptr_q       <= '0;
        end else begin
            entry_update_q     <= entry_update_d;
            entry_update_inv_q <= entry_update_inv_d;
            entry_update_pld_q <= entry_update_pld_d;
            victim_ptr_q       <= victim_ptr_d;
        end
    end

    assign entry_update     = entry_update_q;
    assign entry_update_inv = entry_update_inv_q;
    assign entry_update_pld = entry_update_pld_q;
    assign victim_ptr       = victim_ptr_q;

endmodule

// File: tb/tb_toy_bpu_l0btb_alloc.sv
// Allocator bench: bench-side entry array, sequential reference model, strobe scoreboard.
module tb_toy_bpu_l0btb_alloc;
    import toy_pack::*;

    localparam int N  = 8;
    localparam int FD = 2;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    toy_bpu_l0btb_alloc_if u_if();

    logic           [N-1:0]  ev;
    l0btb_entry_pkg [N-1:0]  ep;
    logic           [N-1:0]  entry_update, entry_update_inv;
    l0btb_entry_pkg          entry_update_pld;
    logic           [IW-1:0] victim_ptr;
`ifdef TOY_BPU_L0BTB_FLUSH_EN
    logic flush = 1'b0;
`endif

    toy_bpu_l0btb_alloc #(.ENTRY_NUM(N), .FIFO_DEPTH(FD)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
`ifdef TOY_BPU_L0BTB_FLUSH_EN
        .flush            (flush),
`endif
        .upd              (u_if),
        .entry_vld        (ev),
        .entry_pld        (ep),
        .entry_update     (entry_update),
        .entry_update_inv (entry_update_inv),
        .entry_update_pld (entry_update_pld),
        .victim_ptr       (victim_ptr)
    );

    typedef struct {
        int             idx;
        bit             inv;
        l0btb_entry_pkg pld;
        int             cyc;
    } exp_t;

    exp_t           exp_q[$];
    bit             ref_vld[N];
    l0btb_entry_pkg ref_pld[N];
    int             ref_vp;
    int             cyc       = 0;
    int             n_cmp     = 0;
    int             n_err     = 0;
    int             n_strobe  = 0;
    int             flush_cyc = -1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // Entries as the real entry instances behave: take the strobe on the next edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev <= '0;
            ep <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (entry_update[i]) begin
                    ev[i] <= !entry_update_inv[i];
                    ep[i] <= entry_update_pld;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: requests applied one at a time in acceptance order.
    function automatic void ref_apply(input bit inv, input l0btb_entry_pkg p, input int acc);
        int h = -1;
        int f = -1;
        int idx;
        for (int i = 0; i < N; i++)
            if (h < 0 && ref_vld[i] && ref_pld[i].tag == p.tag) h = i;
        if (h >= 0) begin
            idx = h;
            if (inv) ref_vld[h] = 0;
            else     ref_pld[h] = p;
        end else if (inv) begin
            return;
        end else begin
            for (int i = 0; i < N; i++)
                if (f < 0 && !ref_vld[i]) f = i;
            if (f >= 0) idx = f;
            else begin
                idx    = ref_vp;
                ref_vp = (ref_vp + 1) % N;
            end
            ref_vld[idx] = 1;
            ref_pld[idx] = p;
        end
        exp_q.push_back('{idx: idx, inv: inv, pld: p, cyc: acc});
    endfunction

    function automatic void ref_clear();
        for (int i = 0; i < N; i++) begin
            ref_vld[i] = 0;
            ref_pld[i] = '0;
        end
        ref_vp = 0;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (entry_update == '0) begin
                chk("inv_when_idle", 64'(entry_update_inv), 64'(0));
            end else if (cyc == flush_cyc) begin
                chk("flush_upd", 64'(entry_update), 64'({N{1'b1}}));
                chk("flush_inv", 64'(entry_update_inv), 64'({N{1'b1}}));
            end else begin
                n_strobe++;
                chk("onehot", 64'($onehot(entry_update)), 64'(1));
                if (exp_q.size() == 0) begin
                    chk("spurious_strobe", 64'(entry_update), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_idx", 64'(entry_update), 64'(1) << e.idx);
                    chk("strobe_inv", 64'(entry_update_inv), e.inv ? (64'(1) << e.idx) : 64'(0));
                    if (!e.inv) chk("strobe_pld", 64'(entry_update_pld), 64'(e.pld));
                    chk("strobe_latency", 64'(cyc), 64'(e.cyc + 2));
                end
            end
        end
    end

    task automatic send(input bit inv, input logic [L0BTB_TAG_W-1:0] tag, input logic [L0BTB_TGT_W-1:0] tgt);
        l0btb_entry_pkg p;
        int tries = 0;
        p.tag = tag;
        p.tgt = tgt;
        @(negedge clk); #2;
        u_if.upd_vld = 1'b1;
        u_if.upd_inv = inv;
        u_if.upd_pld = p;
        #1;
        while (!u_if.upd_rdy && tries < 20) begin
            @(negedge clk); #3;
            tries++;
        end
        if (!u_if.upd_rdy) chk("rdy_timeout", 64'(u_if.upd_rdy), 64'(1));
        else ref_apply(inv, p, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #2;
            u_if.upd_vld = 1'b0;
        end
    endtask

    task automatic chk_entries(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_vld"}, 64'(ev[i]), 64'(ref_vld[i]));
            if (ref_vld[i]) chk({tag, "_pld"}, 64'(ep[i]), 64'(ref_pld[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int dup;
        u_if.upd_vld = 1'b0;
        u_if.upd_inv = 1'b0;
        u_if.upd_pld = '0;
        ref_clear();
        #12;
        chk("rst_upd", 64'(entry_update), 64'(0));
        chk("rst_inv", 64'(entry_update_inv), 64'(0));
        chk("rst_pld", 64'(entry_update_pld), 64'(0));
        chk("rst_vp", 64'(victim_ptr), 64'(0));
        #11 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rdy_after_rst", 64'(u_if.upd_rdy), 64'(1));

        // fill entries 0..7
        for (int i = 0; i < 8; i++) send(0, L0BTB_TAG_W'(8'h10 + i), L0BTB_TGT_W'($urandom));
        idle(4);
        chk("vp_after_fill", 64'(victim_ptr), 64'(0));
        chk("all_valid", 64'(ev), 64'({N{1'b1}}));

        // victim replacement
        send(0, 8'h20, 16'h1234);
        idle(3);
        chk("vp_after_20", 64'(victim_ptr), 64'(1));
        send(0, 8'h21, 16'h2345);
        idle(3);
        chk("vp_after_21", 64'(victim_ptr), 64'(2));

        // back-to-back same tag must not duplicate
        send(0, 8'h30, 16'h3001);
        send(0, 8'h30, 16'h3002);
        idle(4);
        dup = 0;
        for (int i = 0; i < N; i++) if (ev[i] && ep[i].tag == 8'h30) dup++;
        chk("tag30_copies", 64'(dup), 64'(1));
        chk("tag30_tgt", 64'(ep[2].tgt), 64'(16'h3002));
        chk("vp_after_30", 64'(victim_ptr), 64'(3));

        // invalidate hit / miss
        s0 = n_strobe;
        send(1, 8'h15, 16'h0);
        send(1, 8'h99, 16'h0);
        idle(4);
        chk("inv_strobes", 64'(n_strobe - s0), 64'(1));
        chk("ent5_invalid", 64'(ev[5]), 64'(0));
        chk("vp_after_inv", 64'(victim_ptr), 64'(3));

        // six consecutive requests
        s0 = n_strobe;
        for (int i = 0; i < 6; i++) send(0, L0BTB_TAG_W'(8'h60 + i), L0BTB_TGT_W'(i));
        idle(5);
        chk("burst_strobes", 64'(n_strobe - s0), 64'(6));
        chk_entries("dir_ent");

        // reset mid-operation
        send(0, 8'h70, 16'h7);
        send(0, 8'h71, 16'h7);
        @(negedge clk); #2;
        u_if.upd_vld = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        ref_clear();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("no_strobe_post_rst", 64'(entry_update), 64'(0));
        chk("vp_post_rst", 64'(victim_ptr), 64'(0));
        chk("rdy_post_rst", 64'(u_if.upd_rdy), 64'(1));
        idle(3);
        chk("q_empty_post_rst", 64'(exp_q.size()), 64'(0));

        // random traffic
        repeat (300) begin
            if ($urandom_range(9) < 7)
                send($urandom_range(3) == 0, L0BTB_TAG_W'(8'h40 + $urandom_range(11)), L0BTB_TGT_W'($urandom));
            else
                idle(1);
        end
        idle(5);
        chk("rand_q_empty", 64'(exp_q.size()), 64'(0));
        chk("rand_vp", 64'(victim_ptr), 64'(ref_vp));
        chk_entries("rand_ent");

`ifdef TOY_BPU_L0BTB_FLUSH_EN
        send(0, 8'h50, 16'h5);
        send(0, 8'h51, 16'h5);
        @(negedge clk); #2;
        u_if.upd_vld = 1'b0;
        flush = 1'b1;
        #1;
        chk("rdy_in_flush", 64'(u_if.upd_rdy), 64'(0));
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        flush_cyc = cyc + 1;
        ref_clear();
        @(negedge clk); #2;
        flush = 1'b0;
        idle(4);
        chk("vp_after_flush", 64'(victim_ptr), 64'(0));
        chk("q_after_flush", 64'(exp_q.size()), 64'(0));
        chk("ent_after_flush", 64'(ev), 64'(0));
        send(0, 8'h52, 16'h52);
        idle(4);
        chk("alloc_after_flush", 64'(ev), 64'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
